can_tx_scheduler: RTL and testbench



---
 rtl/can_sched_pkg.sv | 38 +++
 rtl/can_prio_sel.sv | 31 +++
 rtl/can_tx_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_can_tx_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/can_sched_pkg.sv
// Shared definitions for the CAN transmit mailbox scheduler.
// Contents: FSM state encoding, controller register selects, status bit
//           positions, and the CAN arbitration-key function.
package can_sched_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEL,
    S_WID,
    S_WD0,
    S_WD1,
    S_WDLC,
    S_GUARD,
    S_POLL,
    S_EVAL
  } state_t;

  // Controller register selects
  localparam logic [1:0] RS_ID    = 2'd0;
  localparam logic [1:0] RS_DLCF  = 2'd1;
  localparam logic [1:0] RS_DATA0 = 2'd2;
  localparam logic [1:0] RS_DATA1 = 2'd3;

  // Controller status bit positions (read via rs=1)
  localparam int ST_RTS   = 8;
  localparam int ST_LOSTF = 9;
  localparam int ST_BITF  = 10;
  localparam int ST_ACKF  = 11;

  // Maps an ID register to a key whose unsigned order matches bus priority:
  // std frames place the 11-bit id on top and beat an ext frame with the
  // same base id (SRR/IDE recessive = 2'b11), RTR loses to data.
  function automatic logic [31:0] arb_key(input logic [31:0] id_reg);
    if (id_reg[31]) arb_key = {id_reg[28:18], 2'b11, id_reg[17:0], id_reg[30]};
    else            arb_key = {id_reg[10:0], id_reg[30], 20'h0};
  endfunction

endpackage

// File: rtl/can_prio_sel.sv
// Combinational minimum-key finder over a mailbox mask.
// Latency: purely combinational, no state.
// Ports: mask/keys in, valid (any bit set) and idx (lowest key, ties to lower index) out.
module can_prio_sel #(
  parameter int NMB = 4
) (
  input  logic [NMB-1:0]         mask,
  input  logic [NMB-1:0][31:0]   keys,
  output logic                   valid,
  output logic [$clog2(NMB)-1:0] idx
);

  localparam int IW = $clog2(NMB);

  logic [31:0] best;

  // Strict less-than while scanning upward keeps the lower index on ties.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    best  = '1;
    for (int i = 0; i < NMB; i++) begin
      if (mask[i] && (!valid || keys[i] < best)) begin
        valid = 1'b1;
        idx   = IW'(i);
        best  = keys[i];
      end
    end
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// Shares one CAN transmitter between NMB mailboxes: arbitrates by CAN priority,
// writes ID/DATA0/DATA1/DLC+strobe, polls rts, then retires/re-queues/fails.
// Latency: load at cycle 0 -> SEL 1, register writes 2..5, guard 6, first poll 7.
// Ports: mb_* software side (load/abort in, pending/done/fail/busy/irq out),
//        can_* register master port toward the controller (can_q = read data).
module can_tx_scheduler
  import can_sched_pkg::*;
#(
  parameter int NMB      = 4,
  parameter int MAXRETRY = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mb_load,
  input  logic [$clog2(NMB)-1:0] mb_sel,
  input  logic [31:0]            mb_id,
  input  logic [3:0]             mb_dlc,
  input  logic [31:0]            mb_data0,
  input  logic [31:0]            mb_data1,
  input  logic [NMB-1:0]         mb_abort,
  output logic [NMB-1:0]         mb_pending,
  output logic [NMB-1:0]         mb_done,
  output logic [NMB-1:0]         mb_fail,
  output logic                   busy,
  output logic                   irq_done,
  output logic                   can_cs,
  output logic [1:0]             can_rs,
  output logic [3:0]             can_bytesel,
  output logic [31:0]            can_d,
  input  logic [31:0]            can_q
);

  localparam int IW = $clog2(NMB);

  state_t          state;
  logic [IW-1:0]   cur;
  logic            abort_lat;
  logic            lost_q, bit_q, ack_q;

  logic [31:0]     id_r  [NMB];
  logic [31:0]     d0_r  [NMB];
  logic [31:0]     d1_r  [NMB];
  logic [3:0]      dlc_r [NMB];
  logic [3:0]      retry_cnt [NMB];

  logic [NMB-1:0]  pending_q, done_q, fail_q;

  logic [NMB-1:0]  inflight, load_vec, abort_idle;
  logic [NMB-1:0]  pend_n, done_n, fail_n;
  logic [NMB-1:0][31:0] keys_n;
  logic            sel_valid;
  logic [IW-1:0]   sel_idx;
  logic            eval_ok, eval_fail, eval_retry;

  // Only rts/lostf/bitf/ackf of the status word matter here.
  logic unused_status;
  assign unused_status = ^{can_q[31:12], can_q[7:0]};

  assign mb_pending = pending_q;
  assign mb_done    = done_q;
  assign mb_fail    = fail_q;

  // EVAL outcome for the in-flight mailbox. An abort arriving in the EVAL
  // cycle itself is honoured too, so no abort is ever silently dropped.
  always_comb begin
    eval_ok    = !lost_q && ack_q && !bit_q;
    eval_retry = !lost_q && !eval_ok;
    eval_fail  = !eval_ok &&
                 (abort_lat || mb_abort[cur] ||
                  (eval_retry && (int'(retry_cnt[cur]) + 1 >= MAXRETRY)));
  end

  // Next-state mailbox flags. Arbitration looks at these, so a mailbox
  // loaded during SEL already competes for the slot being chosen.
  always_comb begin
    inflight   = busy ? (NMB'(1) << cur) : '0;
    load_vec   = mb_load ? ((NMB'(1) << mb_sel) & ~inflight) : '0;
    abort_idle = mb_abort & ~inflight & pending_q;
    pend_n     = pending_q & ~abort_idle;
    done_n     = done_q;
    fail_n     = fail_q | abort_idle;
    if (state == S_EVAL) begin
      if (eval_ok) begin
        pend_n[cur] = 1'b0;
        done_n[cur] = 1'b1;
      end else if (eval_fail) begin
        pend_n[cur] = 1'b0;
        fail_n[cur] = 1'b1;
      end
    end
    // Load overrides an abort to the same idle mailbox.
    pend_n = pend_n | load_vec;
    done_n = done_n & ~load_vec;
    fail_n = fail_n & ~load_vec;
    for (int i = 0; i < NMB; i++) begin
      keys_n[i] = arb_key(load_vec[i] ? mb_id : id_r[i]);
    end
  end

  can_prio_sel #(.NMB(NMB)) u_prio (
    .mask  (pend_n & ~inflight),
    .keys  (keys_n),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  // Mailbox storage, flags and retry counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      done_q    <= '0;
      fail_q    <= '0;
      irq_done  <= 1'b0;
      for (int i = 0; i < NMB; i++) begin
        id_r[i]      <= '0;
        d0_r[i]      <= '0;
        d1_r[i]      <= '0;
        dlc_r[i]     <= '0;
        retry_cnt[i] <= '0;
      end
    end else begin
      pending_q <= pend_n;
      done_q    <= done_n;
      fail_q    <= fail_n;
      irq_done  <= |((done_n & ~done_q) | (fail_n & ~fail_q));
      if (state == S_EVAL && eval_retry) retry_cnt[cur] <= retry_cnt[cur] + 4'd1;
      for (int i = 0; i < NMB; i++) begin
        if (load_vec[i]) begin
          id_r[i]      <= mb_id;
          d0_r[i]      <= mb_data0;
          d1_r[i]      <= mb_data1;
          dlc_r[i]     <= mb_dlc;
          retry_cnt[i] <= '0;
        end
      end
    end
  end

  // Frame sequencing FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cur       <= '0;
      busy      <= 1'b0;
      abort_lat <= 1'b0;
      lost_q    <= 1'b0;
      bit_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      if (busy && mb_abort[cur]) abort_lat <= 1'b1;
      case (state)
        S_IDLE:  if (|pend_n) state <= S_SEL;
        S_SEL: begin
          if (sel_valid) begin
            cur       <= sel_idx;
            busy      <= 1'b1;
            abort_lat <= 1'b0;
            state     <= S_WID;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WID:   state <= S_WD0;
        S_WD0:   state <= S_WD1;
        S_WD1:   state <= S_WDLC;
        S_WDLC:  state <= S_GUARD;
        // rts is registered inside the controller; skip one cycle before polling.
        S_GUARD: state <= S_POLL;
        S_POLL: begin
          if (!can_q[ST_RTS]) begin
            lost_q <= can_q[ST_LOSTF];
            bit_q  <= can_q[ST_BITF];
            ack_q  <= can_q[ST_ACKF];
            state  <= S_EVAL;
          end
        end
        S_EVAL: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register port decoded from state/cur only. Polling uses rs=1 because a
  // read of rs=0 with no lanes would clear the receiver flags.
  always_comb begin
    can_cs      = 1'b0;
    can_rs      = RS_ID;
    can_bytesel = 4'b0000;
    can_d       = '0;
    case (state)
      S_WID:  begin can_cs = 1'b1; can_rs = RS_ID;    can_bytesel = 4'b1111; can_d = id_r[cur]; end
      S_WD0:  begin can_cs = 1'b1; can_rs = RS_DATA0; can_bytesel = 4'b1111; can_d = d0_r[cur]; end
      S_WD1:  begin can_cs = 1'b1; can_rs = RS_DATA1; can_bytesel = 4'b1111; can_d = d1_r[cur]; end
      S_WDLC: begin
        can_cs      = 1'b1;
        can_rs      = RS_DLCF;
        can_bytesel = 4'b0011;
        can_d       = {23'b0, 1'b1, 4'b0, dlc_r[cur]};
      end
      S_POLL: begin can_cs = 1'b1; can_rs = RS_DLCF; can_bytesel = 4'b0000; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed bench for can_tx_scheduler with a small behavioural CAN controller.
// The model strobes on DLC writes, holds rts for a few cycles, then reports
// lostf / ackf / nothing depending on the bench knobs.
module tb_can_tx_scheduler;

  localparam int NMB = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mb_load;
  logic [1:0]     mb_sel;
  logic [31:0]    mb_id, mb_data0, mb_data1;
  logic [3:0]     mb_dlc;
  logic [NMB-1:0] mb_abort;
  logic [NMB-1:0] mb_pending, mb_done, mb_fail;
  logic           busy, irq_done, can_cs;
  logic [1:0]     can_rs;
  logic [3:0]     can_bytesel;
  logic [31:0]    can_d, can_q;

  can_tx_scheduler #(.NMB(NMB), .MAXRETRY(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .mb_load(mb_load), .mb_sel(mb_sel), .mb_id(mb_id), .mb_dlc(mb_dlc),
    .mb_data0(mb_data0), .mb_data1(mb_data1), .mb_abort(mb_abort),
    .mb_pending(mb_pending), .mb_done(mb_done), .mb_fail(mb_fail),
    .busy(busy), .irq_done(irq_done),
    .can_cs(can_cs), .can_rs(can_rs), .can_bytesel(can_bytesel),
    .can_d(can_d), .can_q(can_q)
  );

  always #5 clk = ~clk;

  // ---------------- controller model ----------------
  logic        rts_m, lost_m, bit_m, ack_m;
  int          cnt_m;
  int          lost_made = 0;
  int          lost_target = 0;
  bit          ack_en = 1'b1;
  int          strobes = 0, cs_cnt = 0, irq_cnt = 0, bad_rd = 0;
  logic [31:0] last_d0 = '0;
  logic [31:0] fr_d0[$];

  assign can_q = {20'b0, ack_m, bit_m, lost_m, rts_m, 8'h00};

  always @(posedge clk) begin
    if (irq_done) irq_cnt <= irq_cnt + 1;
    if (can_cs) begin
      cs_cnt <= cs_cnt + 1;
      if (can_rs == 2'd0 && can_bytesel == 4'b0000) bad_rd <= bad_rd + 1;
      if (can_rs == 2'd2 && can_bytesel == 4'b1111) last_d0 <= can_d;
    end
    if (!rst_n) begin
      rts_m <= 1'b0; lost_m <= 1'b0; bit_m <= 1'b0; ack_m <= 1'b0; cnt_m <= 0;
    end else if (can_cs && can_rs == 2'd1 && can_bytesel == 4'b0011 && can_d[8]) begin
      strobes <= strobes + 1;
      fr_d0.push_back(last_d0);
      rts_m <= 1'b1; cnt_m <= 3;
      lost_m <= 1'b0; bit_m <= 1'b0; ack_m <= 1'b0;
    end else if (rts_m) begin
      if (cnt_m == 0) begin
        rts_m <= 1'b0;
        if (lost_made < lost_target) begin
          lost_made <= lost_made + 1;
          lost_m    <= 1'b1;
        end else if (ack_en) begin
          ack_m <= 1'b1;
        end
      end else begin
        cnt_m <= cnt_m - 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one load pulse; returns one cycle later.
  task automatic load(input int sel, input logic [31:0] id, input logic [31:0] d0,
                      input logic [3:0] dlc);
    mb_load  = 1'b1;
    mb_sel   = 2'(sel);
    mb_id    = id;
    mb_data0 = d0;
    mb_data1 = ~d0;
    mb_dlc   = dlc;
    step();
    mb_load  = 1'b0;
  endtask

  int s0, c0, i0, n;

  initial begin
    rst_n = 1'b0; mb_load = 1'b0; mb_sel = '0; mb_id = '0; mb_dlc = '0;
    mb_data0 = '0; mb_data1 = '0; mb_abort = '0;
    step(); step();
    chk("reset_outs", {mb_pending, mb_done, mb_fail, busy, irq_done, can_cs, can_rs,
                       can_bytesel, can_d}, 64'h0);
    rst_n = 1'b1;
    step();

    // --- single frame, exact write sequence and timing ---
    i0 = irq_cnt;
    load(0, 32'h0000_0123, 32'hA1A2A3A4, 4'd2);               // now cycle 1 (SEL)
    chk("sel_quiet", {busy, can_cs}, 64'h0);
    step(); chk("wid",  {can_cs, can_rs, can_bytesel, can_d}, {1'b1, 2'd0, 4'hF, 32'h0000_0123});
    chk("busy_on", busy, 1);
    step(); chk("wd0",  {can_cs, can_rs, can_bytesel, can_d}, {1'b1, 2'd2, 4'hF, 32'hA1A2A3A4});
    step(); chk("wd1",  {can_cs, can_rs, can_bytesel, can_d}, {1'b1, 2'd3, 4'hF, 32'h5E5D5C5B});
    step(); chk("wdlc", {can_cs, can_rs, can_bytesel, can_d}, {1'b1, 2'd1, 4'h3, 32'h0000_0102});
    step(); chk("guard_cs", can_cs, 0);
    step(); chk("poll", {can_cs, can_rs, can_bytesel}, {1'b1, 2'd1, 4'h0});
    for (int k = 0; k < 100 && !mb_done[0]; k++) step();
    chk("done0", mb_done[0], 1);
    chk("irq_with_done", irq_done, 1);
    chk("busy_off", busy, 0);
    step();
    chk("irq_one_pulse", irq_cnt - i0, 1);
    chk("pend_clear", mb_pending, 0);

    // --- priority: MB2 (0x100) beats MB1 (0x200) ---
    load(1, 32'h0000_0200, 32'h11, 4'd1);
    load(2, 32'h0000_0100, 32'h22, 4'd1);
    for (int k = 0; k < 300 && mb_pending != 0; k++) step();
    n = fr_d0.size();
    chk("prio_first",  fr_d0[n-2], 32'h22);
    chk("prio_second", fr_d0[n-1], 32'h11);

    // --- equal keys: MB0 beats MB3 ---
    load(3, 32'h0000_0050, 32'h33, 4'd0);
    load(0, 32'h0000_0050, 32'h44, 4'd0);
    for (int k = 0; k < 300 && mb_pending != 0; k++) step();
    n = fr_d0.size();
    chk("tie_first",  fr_d0[n-2], 32'h44);
    chk("tie_second", fr_d0[n-1], 32'h33);

    // --- lost arbitration three times, then ACK ---
    s0 = strobes;
    lost_target = lost_made + 3;
    load(0, 32'h0000_0007, 32'h55, 4'd8);
    chk("load_clears_done", mb_done[0], 0);
    for (int k = 0; k < 300 && !mb_done[0]; k++) step();
    chk("lost_done", mb_done[0], 1);
    chk("lost_strobes", strobes - s0, 4);
    chk("lost_retry", dut.retry_cnt[0], 0);

    // --- never ACKed: MAXRETRY=3 attempts then fail ---
    s0 = strobes;
    ack_en = 1'b0;
    load(1, 32'h8000_1234, 32'h66, 4'd1);
    for (int k = 0; k < 300 && !mb_fail[1]; k++) step();
    chk("noack_fail", {mb_fail[1], mb_done[1], mb_pending[1]}, 3'b100);
    chk("noack_strobes", strobes - s0, 3);
    ack_en = 1'b1;
    step();

    // --- aborts and ignored load ---
    s0 = strobes;
    load(1, 32'h0000_0020, 32'h77, 4'd1);
    load(0, 32'h0000_0010, 32'hA0, 4'd1);                      // MB0 wins in SEL
    mb_abort = 4'b0010;                                         // MB1 waiting
    step();
    mb_abort = '0;
    chk("abort_idle", {mb_fail[1], mb_pending[1]}, 2'b10);
    for (int k = 0; k < 50 && !(can_cs && can_bytesel == 4'h0); k++) step();
    chk("reach_poll", {can_cs, can_bytesel}, {1'b1, 4'h0});
    mb_abort = 4'b0001;
    step();
    mb_abort = '0;
    load(0, 32'h0000_03FF, 32'hBAD, 4'd3);                      // in flight: ignored
    for (int k = 0; k < 100 && !(mb_done[0] || mb_fail[0]); k++) step();
    chk("abort_acked", {mb_done[0], mb_fail[0]}, 2'b10);
    repeat (10) step();
    chk("abort_strobes", strobes - s0, 1);
    n = fr_d0.size();
    chk("abort_frame", fr_d0[n-1], 32'hA0);
    chk("abort_pend", mb_pending, 0);

    // --- reset during WD0 ---
    load(2, 32'h0000_0300, 32'h88, 4'd1);                      // cycle 1
    step(); step();                                             // cycle 3
    chk("at_wd0", {can_cs, can_rs}, {1'b1, 2'd2});
    rst_n = 1'b0;
    #1;
    chk("rst_outs", {mb_pending, mb_done, mb_fail, busy, irq_done, can_cs, can_rs,
                     can_bytesel, can_d}, 64'h0);
    step(); step();
    rst_n = 1'b1;
    c0 = cs_cnt;
    repeat (20) step();
    chk("rst_no_cs", cs_cnt - c0, 0);
    chk("rst_no_pend", mb_pending, 0);
    chk("no_rx_clear", bad_rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
